// File: rtl/mu_arbiter_pkg.sv
// Shared definitions for the memory_unit port arbiter: state encodings,
// default parameters and the per-master request bundle.
package mu_arbiter_pkg;

  // State encodings are shared with the CPU control unit, so keep them fixed.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic [15:0] PSW_ADDR_DEFAULT = 16'h0FFB;
  localparam int          MAX_HOLD_DEFAULT = 8;

  // One master's request as seen at the arbiter inputs.
  typedef struct packed {
    logic        req;
    logic        we;
    logic        lock;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mst_req_t;

  // Ownership state for a given master index.
  function automatic logic [1:0] own_state(input logic m);
    return m ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mu_rr_pick.sv
// Two-way round-robin select: a lone requester wins outright, a tie goes to
// the master the round-robin pointer favours.
module mu_rr_pick (
  input  logic [1:0] req,
  input  logic       rr_next,
  output logic       valid,
  output logic       winner
);

  // Pure select; the pointer itself lives in the arbiter.
  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? rr_next : req[1];
  end

endmodule

// File: rtl/mu_arbiter.sv
// Two-master arbiter in front of memory_unit's single access port.
// Master 0 is the CPU control unit, master 1 the I/O copy engine.
module mu_arbiter
  import mu_arbiter_pkg::*;
#(
  parameter int          MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter logic [15:0] PSW_ADDR = PSW_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [15:0] rdata,
  output logic        mu_we,
  output logic [15:0] mu_abus,
  output logic [15:0] mu_wbus,
  input  logic [15:0] mu_rbus
);

  localparam int             CW       = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);

  logic [1:0]    state_q, state_d;
  logic          rr_next_q, rr_next_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic          m1_err_q, m1_err_d;
  logic [15:0]   abus_q, abus_d;
  logic [15:0]   wbus_q, wbus_d;

  mst_req_t      m0_s, m1_s, own_s;
  logic          own_sel;
  logic          owned;
  logic          access;
  logic          other_req;
  logic          prot;
  logic [CW-1:0] hold_nxt;
  logic          hold_hit;
  logic          pick_valid;
  logic          pick_winner;

  assign m0_s = '{req: m0_req, we: m0_we, lock: m0_lock, addr: m0_addr, wdata: m0_wdata};
  assign m1_s = '{req: m1_req, we: m1_we, lock: m1_lock, addr: m1_addr, wdata: m1_wdata};

  mu_rr_pick u_pick (
    .req     ({m1_req, m0_req}),
    .rr_next (rr_next_q),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  // Decode the current owner and whether this cycle is an access.
  always_comb begin
    own_sel   = (state_q == ST_OWN1);
    owned     = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    own_s     = own_sel ? m1_s : m0_s;
    access    = owned && own_s.req;
    other_req = own_sel ? m0_req : m1_req;
    // Only the copy engine is barred from the PSW word.
    prot      = own_sel && (own_s.addr == PSW_ADDR);
    hold_nxt  = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + CW'(1);
    hold_hit  = access && (hold_nxt == HOLD_MAX);
  end

  // Grant FSM and round-robin pointer update.
  always_comb begin
    state_d   = state_q;
    rr_next_d = rr_next_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = own_state(pick_winner);
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_s.req) begin
          state_d = other_req ? own_state(~own_sel) : ST_IDLE;
        end else if (other_req && (!own_s.lock || hold_hit)) begin
          // A lock only holds off the other master for MAX_HOLD accesses.
          state_d = own_state(~own_sel);
        end
        if (state_d != state_q) rr_next_d = ~own_sel;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hold counter restarts with every ownership change and saturates.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) hold_cnt_d = '0;
    else if (access)        hold_cnt_d = hold_nxt;
  end

  // Port drive plus read-valid / error tagging for the following cycle.
  always_comb begin
    mu_we       = access && own_s.we && !prot;
    mu_abus     = access ? own_s.addr  : abus_q;
    mu_wbus     = access ? own_s.wdata : wbus_q;
    abus_d      = mu_abus;
    wbus_d      = mu_wbus;
    // rvalid is tagged by who issued the read, not by who owns next cycle.
    m0_rvalid_d = access && !own_sel && !own_s.we;
    m1_rvalid_d = access &&  own_sel && !own_s.we;
    m1_err_d    = access &&  own_sel &&  own_s.we && prot;
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_next_q   <= 1'b0;
      hold_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m1_err_q    <= 1'b0;
      abus_q      <= '0;
      wbus_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_next_q   <= rr_next_d;
      hold_cnt_q  <= hold_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m1_err_q    <= m1_err_d;
      abus_q      <= abus_d;
      wbus_q      <= wbus_d;
    end
  end

  assign m0_gnt    = (state_q == ST_OWN0);
  assign m1_gnt    = (state_q == ST_OWN1);
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_err    = 1'b0;
  assign m1_err    = m1_err_q;
  assign rdata     = mu_rbus;

endmodule
